bram_read_arbiter: RTL and testbench
====================================

BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter LOG_NUM_REQ, default 2: requester index width.
REQ-003 Parameter DATA_WIDTH, default 8: BRAM data width.
REQ-004 Parameter LOG_MAX_ADDRESS, default 16: address width.
REQ-005 Parameter RD_LATENCY, default 1: BRAM request-to-data latency in cycles (1..4).
REQ-006 Parameter MAX_BURST, default 4: maximum consecutive grants to one owner (1..255).
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  synchronous reset, active high.
REQ-010 request_in  in  NUM_REQ  per-requester read request, held until granted.
REQ-011 address_in  in  NUM_REQ*LOG_MAX_ADDRESS  packed addresses; requester i occupies slice i.
REQ-012 grant_out  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted request.
REQ-013 bram_request_out  out  1  read strobe to BRAM.
REQ-014 bram_address_out  out  LOG_MAX_ADDRESS  address of the granted requester.
REQ-015 bram_valid_in  in  1  BRAM read data valid.
REQ-016 bram_data_in  in  DATA_WIDTH  BRAM read data.
REQ-017 valid_out  out  NUM_REQ  one-hot return valid to the requester that issued the read.
REQ-018 data_out  out  DATA_WIDTH  shared return data, equal to bram_data_in.
REQ-019 error_out  out  1  sticky protocol error flag.

Function
REQ-020 FSM states: IDLE (no owner) and OWN (owner register valid).
- IDLE->OWN: any request_in high; winner is selected by the policy (REQ-025).
- OWN->OWN (same owner): owner request high and burst_cnt < MAX_BURST.
- OWN->OWN (new owner): otherwise, if another request is high.
- OWN->IDLE: otherwise.
REQ-021 In a cycle with a winner: grant_out[winner]=1, bram_request_out=1, bram_address_out=address_in[winner]; else all three are 0.
REQ-022 At most one grant per cycle; a grant is never issued to a requester whose request_in is low.
REQ-023 burst_cnt: set to 1 on owner change, incremented on each repeat grant, saturating at MAX_BURST; 8-bit width.
REQ-024 Every grant SHALL push {winner id, 1} into a RD_LATENCY-deep tag shift register; cycles without a grant push {0,0}.
REQ-025 Default policy is round-robin: search starts at (last owner + 1) mod NUM_REQ, with wrap-around; after reset the search starts at index 0.
REQ-026 valid_out[tag_id]=bram_valid_in when the tag at depth RD_LATENCY is valid; data_out=bram_data_in, combinational.
REQ-027 bram_valid_in=1 with an invalid tag, or a valid tag with bram_valid_in=0, SHALL set error_out; valid_out stays 0 in the first case.
REQ-028 error_out clears only on reset.
REQ-029 A request dropped while not granted SHALL be ignored without error.
REQ-030 Zero added latency: the requester sees data exactly RD_LATENCY cycles after its grant.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, round-robin pointer=0, burst_cnt=0, tags cleared, error_out=0.
REQ-032 During and after reset, grant_out, bram_request_out, and valid_out SHALL be 0 until a new grant occurs.
REQ-033 Reset mid-operation discards in-flight tags; BRAM data returning afterwards raises error_out.

Configuration
REQ-034 Macro BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; MAX_BURST still limits owner hold.
- Undefined: round-robin per REQ-025.

Structure
REQ-035 Shared package holds the FSM state encodings (ARB_IDLE=0, ARB_OWN=1) and the tag record width constant.
REQ-036 One sub-module, arb_tag_pipe: the RD_LATENCY-deep shift register of {id, valid}.

Verification
REQ-037 Single requester 2, addr 0x0010, RD_LATENCY=1 -> grant_out=0100 same cycle; valid_out=0100 next cycle with BRAM data.
REQ-038 Requesters 0 and 1 held high continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...
REQ-039 All four requesting, MAX_BURST=1 -> grants 0,1,2,3,0 (round-robin); with BRAM_ARB_FIXED_PRIO_EN, MAX_BURST=1 -> winners 0,1,0,1...
REQ-040 RD_LATENCY=3, back-to-back grants to 1,3,0 -> valid_out=0010,1000,0001 three cycles later, in order.
REQ-041 bram_valid_in pulsed with no grant outstanding -> error_out=1 and stays 1 until rst.
REQ-042 rst asserted with two reads in flight -> outputs 0, state IDLE; the next request is granted to requester 0 first.

Source files
------------

// File: rtl/bram_read_arbiter_pkg.sv
// Shared definitions for the BRAM read arbiter: FSM encodings and the {id, valid}
// tag record layout carried through the read-latency pipe.
package bram_read_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int ARB_TAG_ID_W = 3;
    localparam int ARB_TAG_W    = ARB_TAG_ID_W + 1;

endpackage

// File: rtl/bram_read_arbiter_tag_pipe.sv
// RD_LATENCY-deep shift register of {id, valid} tags; the last stage lines up
// with the BRAM read data belonging to the grant that pushed it.
module arb_tag_pipe
    import bram_read_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARB_TAG_W-1:0] push_tag,
    output logic [ARB_TAG_W-1:0] pop_tag
);

    logic [ARB_TAG_W-1:0] stage [RD_LATENCY];

    // Shift one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_tag = stage[RD_LATENCY-1];

endmodule

// File: rtl/bram_read_arbiter.sv
// Multi-requester BRAM read arbiter with burst-limited ownership and tagged return
// routing. Define BRAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int LOG_NUM_REQ     = 2,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_MAX_ADDRESS = 16,
    parameter int RD_LATENCY      = 1,
    parameter int MAX_BURST       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 request_in,
    input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] address_in,
    output logic [NUM_REQ-1:0]                 grant_out,
    output logic                               bram_request_out,
    output logic [LOG_MAX_ADDRESS-1:0]         bram_address_out,
    input  logic                               bram_valid_in,
    input  logic [DATA_WIDTH-1:0]              bram_data_in,
    output logic [NUM_REQ-1:0]                 valid_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               error_out
);

    localparam logic [7:0]             MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [NUM_REQ-1:0]     ONE_HOT_0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t               state;
    logic [LOG_NUM_REQ-1:0]   owner;
    logic [LOG_NUM_REQ-1:0]   rr_ptr;
    logic [7:0]               burst_cnt;
    logic                     err;

    logic [NUM_REQ-1:0]       cand;
    logic [LOG_NUM_REQ-1:0]   start;
    logic [LOG_NUM_REQ-1:0]   idx;
    logic [LOG_NUM_REQ-1:0]   win;
    logic [LOG_NUM_REQ-1:0]   next_ptr;
    logic                     keep;
    logic                     found;
    logic                     grant_valid;
    logic [ARB_TAG_W-1:0]     push_tag;
    logic [ARB_TAG_W-1:0]     pop_tag;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    assign start = rr_ptr;
`endif

    // Winner selection: keep the owner while its burst allows, else search the
    // other requesters starting from the policy's start index.
    always_comb begin
        cand  = request_in;
        keep  = 1'b0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        if (state == ARB_OWN) begin
            keep        = request_in[owner] && (burst_cnt < MAX_BURST_C);
            cand[owner] = 1'b0;
        end else begin
            keep = 1'b0;
        end
        if (keep) begin
            found = 1'b1;
            win   = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = LOG_NUM_REQ'((int'(start) + k) % NUM_REQ);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end else begin
                    found = found;
                end
            end
        end
    end

    assign grant_valid      = found && !rst;
    assign grant_out        = grant_valid ? (ONE_HOT_0 << win) : '0;
    assign bram_request_out = grant_valid;
    assign bram_address_out = grant_valid ?
                              address_in[int'(win)*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] : '0;
    assign next_ptr         = (int'(win) == NUM_REQ-1) ? '0 : win + LOG_NUM_REQ'(1);
    assign push_tag         = grant_valid ? {ARB_TAG_ID_W'(win), 1'b1} : '0;

    // Ownership FSM with burst counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= 8'd0;
        end else if (grant_valid) begin
            state  <= ARB_OWN;
            owner  <= win;
            rr_ptr <= next_ptr;
            if (keep && (burst_cnt != MAX_BURST_C)) begin
                burst_cnt <= burst_cnt + 8'd1;
            end else if (keep) begin
                burst_cnt <= burst_cnt;
            end else begin
                burst_cnt <= 8'd1;
            end
        end else begin
            state     <= ARB_IDLE;
            burst_cnt <= 8'd0;
        end
    end

    arb_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    assign valid_out = (pop_tag[0] && bram_valid_in && !rst) ?
                       (ONE_HOT_0 << pop_tag[ARB_TAG_W-1:1]) : '0;
    assign data_out  = bram_data_in;

    // Sticky error: BRAM data valid must coincide exactly with a valid tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bram_valid_in != pop_tag[0]) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end

    assign error_out = err;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench: three arbiter instances (defaults, MAX_BURST=1, RD_LATENCY=3) share stimulus.
module tb_bram_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] addr;
    logic        bvalid;
    logic [7:0]  bdata;

    logic [3:0]  grant_a, grant_b, grant_c, valid_a, valid_b, valid_c;
    logic        breq_a, breq_b, breq_c, err_a, err_b, err_c;
    logic [15:0] baddr_a, baddr_b, baddr_c;
    logic [7:0]  data_a, data_b, data_c;

    int checks = 0;
    int errors = 0;

    logic [3:0] pat_burst4 [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`ifdef BRAM_ARB_FIXED_PRIO_EN
    logic [3:0] pat_burst1 [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`else
    logic [3:0] pat_burst1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    always #5 clk = ~clk;

    bram_read_arbiter #(.MAX_BURST(4), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .request_in(req), .address_in(addr),
        .grant_out(grant_a), .bram_request_out(breq_a), .bram_address_out(baddr_a),
        .bram_valid_in(bvalid), .bram_data_in(bdata),
        .valid_out(valid_a), .data_out(data_a), .error_out(err_a));

    bram_read_arbiter #(.MAX_BURST(1), .RD_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .request_in(req), .address_in(addr),
        .grant_out(grant_b), .bram_request_out(breq_b), .bram_address_out(baddr_b),
        .bram_valid_in(bvalid), .bram_data_in(bdata),
        .valid_out(valid_b), .data_out(data_b), .error_out(err_b));

    bram_read_arbiter #(.MAX_BURST(4), .RD_LATENCY(3)) dut_c (
        .clk(clk), .rst(rst), .request_in(req), .address_in(addr),
        .grant_out(grant_c), .bram_request_out(breq_c), .bram_address_out(baddr_c),
        .bram_valid_in(bvalid), .bram_data_in(bdata),
        .valid_out(valid_c), .data_out(data_c), .error_out(err_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; bvalid = 1'b0; bdata = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        addr = 64'h3333_0010_1111_0000;
        rst = 1'b1; req = 4'b1111; bvalid = 1'b1; bdata = 8'h00;
        #1;
        check_val("rst_grant", 32'(grant_a), 32'h0);
        check_val("rst_breq", 32'(breq_a), 32'h0);
        check_val("rst_valid", 32'(valid_a), 32'h0);
        cyc();
        check_val("rst_err", 32'(err_a), 32'h0);
        do_reset();

        // Single requester 2, RD_LATENCY=1
        req = 4'b0100; #1;
        check_val("single_grant", 32'(grant_a), 32'h4);
        check_val("single_breq", 32'(breq_a), 32'h1);
        check_val("single_addr", 32'(baddr_a), 32'h0010);
        cyc();
        req = 4'b0000; bvalid = 1'b1; bdata = 8'hA5; #1;
        check_val("single_valid", 32'(valid_a), 32'h4);
        check_val("single_data", 32'(data_a), 32'hA5);
        check_val("single_nogrant", 32'(grant_a), 32'h0);
        cyc();
        bvalid = 1'b0; #1;
        check_val("single_noerr", 32'(err_a), 32'h0);

        // Two requesters, burst limit 4
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            #1;
            check_val($sformatf("burst4_g%0d", i), 32'(grant_a), 32'(pat_burst4[i]));
            check_val($sformatf("burst4_a%0d", i), 32'(baddr_a),
                      (pat_burst4[i] == 4'b0001) ? 32'h0000 : 32'h1111);
            cyc();
        end
        check_val("burst4_missing_data_err", 32'(err_a), 32'h1);

        // Four requesters, burst limit 1
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("burst1_g%0d", i), 32'(grant_b), 32'(pat_burst1[i]));
            cyc();
        end

        // RD_LATENCY=3, grants 1,3,0 back to back
        do_reset();
        req = 4'b0010; #1;
        check_val("lat3_g1", 32'(grant_c), 32'h2);
        cyc();
        req = 4'b1000; #1;
        check_val("lat3_g3", 32'(grant_c), 32'h8);
        cyc();
        req = 4'b0001; #1;
        check_val("lat3_g0", 32'(grant_c), 32'h1);
        cyc();
        req = 4'b0000; bvalid = 1'b1; bdata = 8'h11; #1;
        check_val("lat3_v1", 32'(valid_c), 32'h2);
        check_val("lat3_d1", 32'(data_c), 32'h11);
        cyc();
        bdata = 8'h22; #1;
        check_val("lat3_v3", 32'(valid_c), 32'h8);
        cyc();
        bdata = 8'h33; #1;
        check_val("lat3_v0", 32'(valid_c), 32'h1);
        cyc();
        bvalid = 1'b0; #1;
        check_val("lat3_noerr", 32'(err_c), 32'h0);
        check_val("lat3_idle_valid", 32'(valid_c), 32'h0);
        cyc();
        check_val("lat3_noerr2", 32'(err_c), 32'h0);

        // Spurious BRAM valid
        do_reset();
        bvalid = 1'b1; #1;
        check_val("spur_valid", 32'(valid_a), 32'h0);
        cyc();
        bvalid = 1'b0; #1;
        check_val("spur_err", 32'(err_a), 32'h1);
        repeat (3) cyc();
        check_val("spur_sticky", 32'(err_a), 32'h1);
        rst = 1'b1;
        cyc();
        check_val("spur_clear", 32'(err_a), 32'h0);
        rst = 1'b0;

        // Reset with reads in flight
        do_reset();
        req = 4'b0100; #1;
        check_val("mid_g2", 32'(grant_c), 32'h4);
        cyc();
        req = 4'b1000; #1;
        check_val("mid_g3", 32'(grant_c), 32'h8);
        cyc();
        rst = 1'b1; req = 4'b1111; #1;
        check_val("mid_rst_grant", 32'(grant_c), 32'h0);
        check_val("mid_rst_breq", 32'(breq_c), 32'h0);
        check_val("mid_rst_valid", 32'(valid_c), 32'h0);
        cyc();
        rst = 1'b0; #1;
        check_val("mid_first_grant", 32'(grant_c), 32'h1);
        check_val("mid_first_addr", 32'(baddr_c), 32'h0000);
        cyc();
        req = 4'b0000; bvalid = 1'b1; #1;
        check_val("mid_late_valid", 32'(valid_c), 32'h0);
        cyc();
        bvalid = 1'b0; #1;
        check_val("mid_late_err", 32'(err_c), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
